// File: rtl/store_block.sv
// rtl/store_block.sv - write-back engine: copies size*size words from the image buffer to memory
// One word per FETCH/WRITE pair; the write is held on the port until dmaReady accepts it.
module store_block #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int MAX_PIX = 1024,
   parameter int BUF_AW  = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [15:0]       size,
   input  logic [ADDR_W-1:0] address,
   output logic [BUF_AW-1:0] bufAddr,
   input  logic [DATA_W-1:0] bufData,
   output logic              dmaWrite,
   output logic [ADDR_W-1:0] dmaAddr,
   output logic [DATA_W-1:0] dmaData,
   input  logic              dmaReady,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {IDLE, CALC, FETCH, WRITE, DONE} state_t;

   localparam logic [BUF_AW-1:0] IDX_ONE = 1;

   state_t            state, state_nxt;
   logic [15:0]       size_q;
   logic [ADDR_W-1:0] base;
   logic [BUF_AW-1:0] idx;
   logic              armed;
   logic [31:0]       total;
   logic              start, last, oversize;

   assign total    = {16'd0, size_q} * {16'd0, size_q};
   assign oversize = total > 32'(MAX_PIX);
   assign start    = (state == IDLE) && enable && armed;
   assign last     = ({{(32-BUF_AW){1'b0}}, idx} == (total - 32'd1));

   assign dmaWrite = (state == WRITE);
   assign busy     = (state != IDLE);
   assign done     = (state == DONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CALC;
         CALC:    state_nxt = (size_q == 16'd0 || oversize) ? DONE : FETCH;
         FETCH:   state_nxt = WRITE;
         WRITE:   if (dmaReady) state_nxt = last ? DONE : FETCH;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // armed blocks a level-held enable from starting a second run
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         armed   <= 1'b0;
         size_q  <= '0;
         base    <= '0;
         idx     <= '0;
         err     <= 1'b0;
         bufAddr <= '0;
         dmaAddr <= '0;
         dmaData <= '0;
      end else begin
         if (!enable)    armed <= 1'b1;
         else if (start) armed <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  size_q <= size;
                  base   <= address;
                  idx    <= '0;
                  err    <= 1'b0;
               end
            end
            CALC: begin
               if (size_q != 16'd0 && oversize) err <= 1'b1;
               bufAddr <= idx;
            end
            FETCH: begin
               dmaData <= bufData;
               dmaAddr <= base + ADDR_W'(idx);
            end
            WRITE: begin
               if (dmaReady && !last) begin
                  idx     <= idx + IDX_ONE;
                  bufAddr <= idx + IDX_ONE;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_store_block.sv
// tb/tb_store_block.sv - directed bench for store_block
// Edges are numbered by cyc; E0 is the edge that samples enable.
module tb_store_block;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [15:0] size;
   logic [15:0] address;
   logic [9:0]  bufAddr;
   logic [15:0] bufData;
   logic        dmaWrite;
   logic [15:0] dmaAddr;
   logic [15:0] dmaData;
   logic        dmaReady;
   logic        busy;
   logic        done;
   logic        err;

   logic [15:0] mem [0:1023];
   logic [15:0] wa[$];
   logic [15:0] wd[$];
   int          we[$];
   int          cyc = 0;
   int          done_cnt = 0;
   int          done_edge = 0;
   int          wr_cycles = 0;
   int          checks = 0;
   int          failures = 0;
   int          e0, d0, w0, wc0;

   store_block dut (
      .clk(clk), .reset(reset), .enable(enable), .size(size), .address(address),
      .bufAddr(bufAddr), .bufData(bufData), .dmaWrite(dmaWrite), .dmaAddr(dmaAddr),
      .dmaData(dmaData), .dmaReady(dmaReady), .busy(busy), .done(done), .err(err)
   );

   assign bufData = mem[bufAddr];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // a write seen at the negedge with dmaReady high is accepted at the next edge
   always @(negedge clk) begin
      if (!reset) begin
         if (dmaWrite) wr_cycles <= wr_cycles + 1;
         if (dmaWrite && dmaReady) begin
            wa.push_back(dmaAddr);
            wd.push_back(dmaData);
            we.push_back(cyc + 1);
         end
         if (done) begin
            done_cnt  <= done_cnt + 1;
            done_edge <= cyc;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_edge(input int n);
      for (int g = 0; g < 5000 && cyc < n; g++) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic start_run(input logic [15:0] sz, input logic [15:0] ad, input bit hold);
      d0  = done_cnt;
      w0  = wa.size();
      wc0 = wr_cycles;
      size    = sz;
      address = ad;
      enable  = 1'b1;
      e0 = cyc + 1;
      if (!hold) begin
         step(1);
         enable  = 1'b0;
         size    = 16'h5555;
         address = 16'hAAAA;
      end
   endtask

   task automatic wait_done();
      for (int g = 0; g < 3000 && done_cnt == d0; g++) step(1);
      step(2);
   endtask

   task automatic verify(input int n, input logic [15:0] base, input int stall_k, input int stall_n);
      logic [15:0] ea, ed;
      int          ee;
      check("nwrites", wa.size() - w0, n);
      check("wrcycles", wr_cycles - wc0, n + stall_n);
      for (int k = 0; k < n && (w0 + k) < wa.size(); k++) begin
         ea = base + 16'(k);
         ed = 16'(k * 7 - 20);
         ee = e0 + 2 * k + 3 + ((k >= stall_k) ? stall_n : 0);
         check("waddr", wa[w0 + k], ea);
         check("wdata", wd[w0 + k], ed);
         check("wedge", we[w0 + k], ee);
      end
      check("ndone", done_cnt - d0, 1);
      check("doneedge", done_edge, e0 + 2 * n + 1 + stall_n);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 7 - 20);
      reset    = 1'b1;
      enable   = 1'b0;
      size     = '0;
      address  = '0;
      dmaReady = 1'b1;
      step(2);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_dmawrite", dmaWrite, 0);
      check("rst_dmaaddr", dmaAddr, 0);
      check("rst_dmadata", dmaData, 0);
      check("rst_bufaddr", bufAddr, 0);
      reset = 1'b0;
      step(2);

      // basic transfer
      start_run(16'd3, 16'd100, 1'b0);
      check("calc_busy", busy, 1);
      wait_done();
      verify(9, 16'd100, 9, 0);
      check("basic_err", err, 0);
      check("basic_idle", busy, 0);

      // backpressure on word 4
      start_run(16'd3, 16'd100, 1'b0);
      wait_edge(e0 + 9);
      dmaReady = 1'b0;
      for (int s = 0; s < 3; s++) begin
         wait_edge(e0 + 10 + s);
         check("bp_write", dmaWrite, 1);
         check("bp_addr", dmaAddr, 16'd104);
         check("bp_data", dmaData, 16'd8);
      end
      wait_edge(e0 + 13);
      dmaReady = 1'b1;
      wait_done();
      verify(9, 16'd100, 4, 3);

      // zero size, oversize, then a legal start clears err
      start_run(16'd0, 16'd50, 1'b0);
      wait_done();
      verify(0, 16'd50, 0, 0);
      check("zero_err", err, 0);
      start_run(16'd33, 16'd50, 1'b0);
      wait_done();
      verify(0, 16'd50, 0, 0);
      check("over_err", err, 1);
      start_run(16'd2, 16'd300, 1'b0);
      check("err_clear", err, 0);
      wait_done();
      verify(4, 16'd300, 4, 0);

      // largest legal image
      start_run(16'd32, 16'd0, 1'b0);
      wait_done();
      verify(1024, 16'd0, 1024, 0);
      check("max_err", err, 0);

      // wrap with enable held high, then re-arm
      start_run(16'd2, 16'hFFFE, 1'b1);
      wait_edge(e0 + 30);
      verify(4, 16'hFFFE, 4, 0);
      check("hold_busy", busy, 0);
      enable = 1'b0;
      step(1);
      start_run(16'd2, 16'h0010, 1'b0);
      wait_done();
      verify(4, 16'h0010, 4, 0);

      // asynchronous reset during word 4 (the fifth word)
      start_run(16'd4, 16'd200, 1'b0);
      wait_edge(e0 + 10);
      check("pre_rst_write", dmaWrite, 1);
      reset = 1'b1;
      #1;
      check("mid_rst_write", dmaWrite, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_writes", wa.size() - w0, 4);
      step(2);
      enable = 1'b1;
      reset  = 1'b0;
      step(5);
      check("rst_noarm_busy", busy, 0);
      check("rst_nowrites", wa.size() - w0, 4);
      check("rst_nodone", done_cnt - d0, 0);
      enable = 1'b0;
      step(1);
      start_run(16'd4, 16'd200, 1'b0);
      wait_done();
      verify(16, 16'd200, 16, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
